// File: rtl/scc_pkg.sv
// scc_pkg: shared register-file widths, writeback entry type and path-select codes.
package scc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = 3'd7;
  localparam logic WB_SEL_ALU = 1'b1;
  localparam logic WB_SEL_ID = 1'b0;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  function automatic logic [NREG-1:0] pend_bit(input wb_entry_t e);
    return (e.valid && e.addr != ZERO_REG) ? ({{(NREG-1){1'b0}}, 1'b1} << e.addr) : '0;
  endfunction
endpackage

// File: rtl/wb_slot.sv
// wb_slot: single-entry holding register that can drain and reload in the same cycle.
module wb_slot
  import scc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              ready,
  output logic              load,
  output wb_entry_t         entry
);
  assign ready = !entry.valid || drain;
  assign load = in_valid && ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry <= '0;
    else if (load) entry <= '{valid: 1'b1, addr: in_addr, data: in_data};
    else if (drain) entry.valid <= 1'b0;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU and decoder results onto the register-file write port, oldest first.
module reg_writeback
  import scc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_addr,
  input  logic [DATA_W-1:0] id_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_value_alu,
  output logic [DATA_W-1:0] write_value_id,
  output logic              write_data_sel,
  output logic              write_enable,
  output logic [NREG-1:0]   pending_mask
);
  wb_entry_t a_e, i_e;
  logic load_a, load_i, drain_a, drain_i, a_older;
  wb_slot slot_a (
    .clk(clk), .rst_n(rst_n), .in_valid(alu_valid), .in_addr(alu_addr), .in_data(alu_data),
    .drain(drain_a), .ready(alu_ready), .load(load_a), .entry(a_e)
  );
  wb_slot slot_i (
    .clk(clk), .rst_n(rst_n), .in_valid(id_valid), .in_addr(id_addr), .in_data(id_data),
    .drain(drain_i), .ready(id_ready), .load(load_i), .entry(i_e)
  );
  assign drain_a = a_e.valid && (!i_e.valid || a_older);
  assign drain_i = i_e.valid && !drain_a;
  // a_older: slot A holds the earlier-accepted entry; a slot reloaded beside a staying entry is the younger one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_older <= 1'b1;
    else if (load_a && load_i) a_older <= 1'b1;
    else if (load_a) a_older <= !(i_e.valid && !drain_i);
    else if (load_i) a_older <= a_e.valid && !drain_a;
  end
  always_comb begin
    write_data_sel = drain_a ? WB_SEL_ALU : WB_SEL_ID;
    write_addr = drain_a ? a_e.addr : drain_i ? i_e.addr : '0;
    write_enable = (drain_a || drain_i) && write_addr != ZERO_REG;
    write_value_alu = a_e.data;
    write_value_id = i_e.data;
    pending_mask = pend_bit(a_e) | pend_bit(i_e);
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: scoreboard bench; accepted beats must reach the write port in acceptance order.
module tb_reg_writeback;
  import scc_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, id_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0, id_addr = '0;
  logic [DATA_W-1:0] alu_data = '0, id_data = '0;
  logic alu_ready, id_ready, write_data_sel, write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_value_alu, write_value_id;
  logic [NREG-1:0] pending_mask;
  typedef struct {
    logic sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, writes = 0;
  logic alt_en = 1'b0, have_last = 1'b0, last_sel = 1'b0;
  logic [DATA_W-1:0] rf [NREG];
  always #5 clk = ~clk;
  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_data(id_data),
    .write_addr(write_addr), .write_value_alu(write_value_alu), .write_value_id(write_value_id),
    .write_data_sel(write_data_sel), .write_enable(write_enable), .pending_mask(pending_mask)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Reference: every accepted non-zero-register beat is written exactly once, in acceptance order (ALU first on a tie)
  task automatic monitor();
    logic [NREG-1:0] m;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        have_last = 1'b0;
      end else begin
        m = '0;
        foreach (exp_q[k]) m[exp_q[k].addr] = 1'b1;
        chk("pending_mask", 64'(pending_mask), 64'(m));
        if (write_enable) begin
          writes++;
          chk("write_has_entry", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_sel", 64'(write_data_sel), 64'(e.sel));
            chk("write_addr", 64'(write_addr), 64'(e.addr));
            chk("write_value", 64'(e.sel ? write_value_alu : write_value_id), 64'(e.data));
          end
          rf[write_addr] = write_data_sel ? write_value_alu : write_value_id;
          if (alt_en) begin
            if (have_last) chk("alternation", 64'(write_data_sel), 64'(!last_sel));
            have_last = 1'b1;
            last_sel = write_data_sel;
          end
        end
        if (alu_valid && alu_ready && alu_addr != ZERO_REG) exp_q.push_back('{1'b1, alu_addr, alu_data});
        if (id_valid && id_ready && id_addr != ZERO_REG) exp_q.push_back('{1'b0, id_addr, id_data});
      end
    end
  endtask
  initial begin
    int na, ni, w0, cyc;
    logic sa, si;
    foreach (rf[k]) rf[k] = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_we", 64'(write_enable), 64'(0));
    chk("in_reset_mask", 64'(pending_mask), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    chk("rst_id_ready", 64'(id_ready), 64'(1));
    chk("rst_sel", 64'(write_data_sel), 64'(0));
    chk("rst_addr", 64'(write_addr), 64'(0));
    chk("rst_values", {write_value_alu, write_value_id}, 64'(0));
    // single ALU beat
    tick();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("single_we", 64'(write_enable), 64'(1));
    chk("single_sel", 64'(write_data_sel), 64'(1));
    chk("single_addr", 64'(write_addr), 64'(3));
    chk("single_value", 64'(write_value_alu), 64'hDEADBEEF);
    chk("single_mask", 64'(pending_mask), 64'h08);
    tick();
    @(negedge clk);
    chk("single_mask_clear", 64'(pending_mask), 64'(0));
    chk("single_we_clear", 64'(write_enable), 64'(0));
    // simultaneous beats to the same register
    tick();
    alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 32'h11;
    id_valid = 1'b1; id_addr = 3'd2; id_data = 32'h22;
    tick();
    alu_valid = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("sim_first_sel", 64'(write_data_sel), 64'(1));
    chk("sim_first_value", 64'(write_value_alu), 64'h11);
    chk("sim_id_ready", 64'(id_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("sim_second_sel", 64'(write_data_sel), 64'(0));
    chk("sim_second_value", 64'(write_value_id), 64'h22);
    tick();
    @(negedge clk);
    chk("sim_reg2", 64'(rf[2]), 64'h22);
    // ID then ALU on consecutive edges, same register
    tick();
    id_valid = 1'b1; id_addr = 3'd5; id_data = 32'hA5;
    tick();
    id_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 32'h5A;
    @(negedge clk);
    chk("order_first_sel", 64'(write_data_sel), 64'(0));
    chk("order_first_value", 64'(write_value_id), 64'hA5);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("order_second_sel", 64'(write_data_sel), 64'(1));
    tick();
    @(negedge clk);
    chk("order_reg5", 64'(rf[5]), 64'h5A);
    // zero-register writes from each source
    tick();
    alu_valid = 1'b1; alu_addr = ZERO_REG; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("zero_alu_we", 64'(write_enable), 64'(0));
    chk("zero_alu_ready", 64'(alu_ready), 64'(1));
    chk("zero_alu_value", 64'(write_value_alu), 64'h55);
    chk("zero_alu_mask", 64'(pending_mask), 64'(0));
    tick();
    id_valid = 1'b1; id_addr = ZERO_REG; id_data = 32'h66;
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("zero_id_we", 64'(write_enable), 64'(0));
    chk("zero_id_ready", 64'(id_ready), 64'(1));
    chk("zero_id_mask", 64'(pending_mask), 64'(0));
    // sustained contention, 10 beats per source
    tick();
    alt_en = 1'b1; have_last = 1'b0; w0 = writes; na = 0; ni = 0; cyc = 0;
    alu_valid = 1'b1; alu_addr = '0; alu_data = 32'h1000;
    id_valid = 1'b1; id_addr = '0; id_data = 32'h2000;
    while ((na < 10 || ni < 10) && cyc < 40) begin
      @(negedge clk);
      sa = alu_valid && alu_ready;
      si = id_valid && id_ready;
      tick();
      cyc++;
      if (sa) na++;
      if (si) ni++;
      alu_valid = na < 10; alu_addr = ADDR_W'(na % 7); alu_data = 32'h1000 + 32'(na);
      id_valid = ni < 10; id_addr = ADDR_W'(ni % 7); id_data = 32'h2000 + 32'(ni);
    end
    chk("contention_done", 64'(na == 10 && ni == 10), 64'(1));
    repeat (3) tick();
    alt_en = 1'b0;
    chk("contention_writes", 64'(writes - w0), 64'(20));
    // reset with both slots full
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 32'hA1;
    id_valid = 1'b1; id_addr = 3'd4; id_data = 32'hB4;
    tick();
    alu_valid = 1'b0; id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(write_enable), 64'(0));
    chk("midrst_mask", 64'(pending_mask), 64'(0));
    chk("midrst_ready", 64'({alu_ready, id_ready}), 64'(3));
    tick();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("postrst_we", 64'(write_enable), 64'(1));
    chk("postrst_addr", 64'(write_addr), 64'(6));
    chk("postrst_value", 64'(write_value_alu), 64'h77);
    // randomized traffic, including addr/data churn while stalled
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      sa = alu_valid && alu_ready;
      si = id_valid && id_ready;
      tick();
      if (!alu_valid || sa) begin
        alu_valid = $urandom_range(0, 99) < 60;
        alu_addr = ADDR_W'($urandom_range(0, 7)); alu_data = $urandom;
      end else if ($urandom_range(0, 99) < 20) begin
        alu_addr = ADDR_W'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!id_valid || si) begin
        id_valid = $urandom_range(0, 99) < 60;
        id_addr = ADDR_W'($urandom_range(0, 7)); id_data = $urandom;
      end else if ($urandom_range(0, 99) < 20) begin
        id_addr = ADDR_W'($urandom_range(0, 7)); id_data = $urandom;
      end
    end
    @(negedge clk);
    tick();
    alu_valid = 1'b0; id_valid = 1'b0;
    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
